pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline sequencing and hazard controller that supersedes the fixed four-stage stall logic of the core control unit.
- Tracks a valid/destination entry per post-ID stage and produces per-stage stall and bubble control.
- Handles three cases: RAW interlock against in-flight writes, multi-cycle memory data access, and branch flush.
- Sits between the ID decoder (source and destination fields) and the EX branch evaluator (branch-taken flag).

---
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline sequencing, RAW interlock, memory hold and branch flush control
module pipe_hazard_ctrl #(
    parameter int STAGES    = 3,
    parameter int REG_AW    = 4,
    parameter int MEM_CW    = 4,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs_a,
    input  logic [REG_AW-1:0] i_id_rs_b,
    input  logic              i_id_rs_a_en,
    input  logic              i_id_rs_b_en,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_rd_en,
    input  logic [MEM_CW-1:0] i_id_mem_cycles,
    input  logic              i_branch_met,
    output logic [STAGES:0]   o_stall,
    output logic [STAGES-1:0] o_valid,
    output logic              o_flush,
    output logic              o_raw_hazard,
    output logic              o_mem_wait
);

    localparam int HZ_LAST = WB_BYPASS ? STAGES - 2 : STAGES - 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] rd_en_q, rd_en_d;
    logic [REG_AW-1:0] rd_q [STAGES];
    logic [REG_AW-1:0] rd_d [STAGES];
    // Only the EX entry needs its cycle count: it is consumed on the move into MEM.
    logic [MEM_CW-1:0] ex_mcyc_q, ex_mcyc_d;
    logic [MEM_CW-1:0] cnt_q, cnt_d;
    logic              flush_q, flush_d;

    logic mem_hold;
    logic branch_acc;
    logic raw_hit;

    always_comb begin
        raw_hit = 1'b0;
        for (int k = 0; k <= HZ_LAST; k++) begin
            if (valid_q[k] && rd_en_q[k] &&
                ((i_id_rs_a_en && (i_id_rs_a == rd_q[k])) ||
                 (i_id_rs_b_en && (i_id_rs_b == rd_q[k])))) begin
                raw_hit = 1'b1;
            end
        end
    end

    assign mem_hold     = (cnt_q != '0);
    assign branch_acc   = i_branch_met && valid_q[0] && !mem_hold;
    assign o_raw_hazard = i_id_valid && raw_hit;
    assign o_mem_wait   = mem_hold;
    assign o_valid      = valid_q;
    assign o_flush      = flush_q;

    always_comb begin
        o_stall = '0;
        if (mem_hold) begin
            o_stall[2:0] = 3'b111;
        end else if (o_raw_hazard && !branch_acc) begin
            o_stall[0] = 1'b1;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        rd_en_d   = rd_en_q;
        rd_d      = rd_q;
        ex_mcyc_d = ex_mcyc_q;
        cnt_d     = cnt_q;
        flush_d   = 1'b0;
        if (mem_hold) begin
            cnt_d = cnt_q - MEM_CW'(1);
            for (int k = STAGES - 1; k >= 3; k--) begin
                valid_d[k] = valid_q[k-1];
                rd_en_d[k] = rd_en_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
            valid_d[2] = 1'b0;
            rd_en_d[2] = 1'b0;
            rd_d[2]    = '0;
        end else begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                valid_d[k] = valid_q[k-1];
                rd_en_d[k] = rd_en_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
            if (valid_q[0] && (ex_mcyc_q > MEM_CW'(1))) begin
                cnt_d = ex_mcyc_q - MEM_CW'(1);
            end
            // A taken branch squashes ID even when it is also interlocked.
            if (branch_acc || o_raw_hazard) begin
                valid_d[0] = 1'b0;
                rd_en_d[0] = 1'b0;
                rd_d[0]    = '0;
                ex_mcyc_d  = '0;
            end else begin
                valid_d[0] = i_id_valid;
                rd_en_d[0] = i_id_rd_en;
                rd_d[0]    = i_id_rd;
                ex_mcyc_d  = i_id_mem_cycles;
            end
            flush_d = branch_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            rd_en_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k] <= '0;
            end
            ex_mcyc_q <= '0;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rd_en_q   <= rd_en_d;
            rd_q      <= rd_d;
            ex_mcyc_q <= ex_mcyc_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector table plus randomized reference-model check
module tb_pipe_hazard_ctrl;

    localparam int S  = 3;
    localparam int AW = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic          rst;
        logic          idv;
        logic [AW-1:0] rsa;
        logic          rsa_en;
        logic [AW-1:0] rsb;
        logic          rsb_en;
        logic [AW-1:0] rd;
        logic          rd_en;
        logic [CW-1:0] mem;
        logic          br;
    } in_t;

    typedef struct packed {
        in_t          stim;
        logic [S-1:0] v;
        logic [S:0]   st;
        logic         raw;
        logic         mw;
        logic         fl;
    } vec_t;

    // Reference view: which stages hold a writer, and how many extra MEM cycles remain.
    typedef struct packed {
        logic [S-1:0]         v;
        logic [S-1:0]         we;
        logic [S-1:0][AW-1:0] rd;
        logic [CW-1:0]        ex_mc;
        logic [CW-1:0]        left;
        logic                 fl;
    } ms_t;

    typedef struct packed {
        logic [S-1:0] v;
        logic [S:0]   st;
        logic         raw;
        logic         mw;
        logic         fl;
    } mo_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] rs_a, rs_b, rd;
    logic          rs_a_en, rs_b_en, rd_en;
    logic [CW-1:0] mem_cycles;
    logic          branch_met;

    logic [S:0]   stall_a, stall_b;
    logic [S-1:0] valid_a, valid_b;
    logic         flush_a, flush_b, raw_a, raw_b, mw_a, mw_b;

    int   checks = 0;
    int   errors = 0;
    int   stepno = 0;
    ms_t  ma, mb;
    logic raw_a_seen, raw_b_seen;
    vec_t tbl [47];
    vec_t none;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STAGES(S), .REG_AW(AW), .MEM_CW(CW), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .i_id_valid(id_valid),
        .i_id_rs_a(rs_a), .i_id_rs_b(rs_b), .i_id_rs_a_en(rs_a_en), .i_id_rs_b_en(rs_b_en),
        .i_id_rd(rd), .i_id_rd_en(rd_en), .i_id_mem_cycles(mem_cycles), .i_branch_met(branch_met),
        .o_stall(stall_a), .o_valid(valid_a), .o_flush(flush_a),
        .o_raw_hazard(raw_a), .o_mem_wait(mw_a)
    );

    pipe_hazard_ctrl #(.STAGES(S), .REG_AW(AW), .MEM_CW(CW), .WB_BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .i_id_valid(id_valid),
        .i_id_rs_a(rs_a), .i_id_rs_b(rs_b), .i_id_rs_a_en(rs_a_en), .i_id_rs_b_en(rs_b_en),
        .i_id_rd(rd), .i_id_rd_en(rd_en), .i_id_mem_cycles(mem_cycles), .i_branch_met(branch_met),
        .o_stall(stall_b), .o_valid(valid_b), .o_flush(flush_b),
        .o_raw_hazard(raw_b), .o_mem_wait(mw_b)
    );

    function automatic in_t mi(bit r, bit idv, int ra, bit ae, int rb, bit be,
                               int d, bit we, int m, bit b);
        in_t x;
        x.rst = r;  x.idv = idv;
        x.rsa = AW'(ra); x.rsa_en = ae;
        x.rsb = AW'(rb); x.rsb_en = be;
        x.rd  = AW'(d);  x.rd_en  = we;
        x.mem = CW'(m);  x.br     = b;
        return x;
    endfunction

    function automatic vec_t mk(in_t x, int v, int st, bit raw, bit mw, bit fl);
        vec_t e;
        e.stim = x; e.v = S'(v); e.st = (S+1)'(st);
        e.raw = raw; e.mw = mw; e.fl = fl;
        return e;
    endfunction

    function automatic logic m_hazard(ms_t s, in_t x, bit byp);
        int   last = byp ? S - 2 : S - 1;
        logic h = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (s.v[k] && s.we[k] &&
                ((x.rsa_en && x.rsa == s.rd[k]) || (x.rsb_en && x.rsb == s.rd[k])))
                h = 1'b1;
        end
        return h && x.idv;
    endfunction

    function automatic mo_t m_out(ms_t s, in_t x, bit byp);
        mo_t o;
        bit  taken;
        o.v   = s.v;
        o.fl  = s.fl;
        o.mw  = (s.left != 0);
        o.raw = m_hazard(s, x, byp);
        taken = x.br && s.v[0] && !o.mw;
        o.st  = '0;
        if (o.mw) o.st = (S+1)'(7);
        else if (o.raw && !taken) o.st = (S+1)'(1);
        return o;
    endfunction

    function automatic ms_t m_next(ms_t s, in_t x, bit byp);
        ms_t n = s;
        bit  taken, squash;
        if (x.rst) return '0;
        n.fl = 1'b0;
        if (s.left != 0) begin
            n.left = s.left - 1'b1;
            for (int k = S - 1; k >= 3; k--) begin
                n.v[k] = s.v[k-1]; n.we[k] = s.we[k-1]; n.rd[k] = s.rd[k-1];
            end
            n.v[2] = 1'b0; n.we[2] = 1'b0;
        end else begin
            for (int k = S - 1; k >= 1; k--) begin
                n.v[k] = s.v[k-1]; n.we[k] = s.we[k-1]; n.rd[k] = s.rd[k-1];
            end
            n.left = (s.v[0] && s.ex_mc > 1) ? s.ex_mc - 1'b1 : '0;
            taken  = x.br && s.v[0];
            squash = taken || m_hazard(s, x, byp);
            n.v[0]  = x.idv && !squash;
            n.we[0] = x.rd_en && !squash;
            n.rd[0] = x.rd;
            n.ex_mc = squash ? '0 : x.mem;
            n.fl    = taken;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got %0h expected %0h", nm, stepno, act, exp);
        end
    endtask

    task automatic apply(input in_t x);
        rst = x.rst; id_valid = x.idv;
        rs_a = x.rsa; rs_a_en = x.rsa_en;
        rs_b = x.rsb; rs_b_en = x.rsb_en;
        rd = x.rd; rd_en = x.rd_en;
        mem_cycles = x.mem; branch_met = x.br;
    endtask

    task automatic step(input in_t x, input bit has_exp, input vec_t e);
        mo_t oa, ob;
        ms_t na, nb;
        apply(x);
        #1;
        oa = m_out(ma, x, 1'b1);
        ob = m_out(mb, x, 1'b0);
        chk("valid_byp",  32'(valid_a), 32'(oa.v));
        chk("stall_byp",  32'(stall_a), 32'(oa.st));
        chk("raw_byp",    32'(raw_a),   32'(oa.raw));
        chk("memw_byp",   32'(mw_a),    32'(oa.mw));
        chk("flush_byp",  32'(flush_a), 32'(oa.fl));
        chk("valid_nb",   32'(valid_b), 32'(ob.v));
        chk("stall_nb",   32'(stall_b), 32'(ob.st));
        chk("raw_nb",     32'(raw_b),   32'(ob.raw));
        chk("memw_nb",    32'(mw_b),    32'(ob.mw));
        chk("flush_nb",   32'(flush_b), 32'(ob.fl));
        if (has_exp) begin
            chk("tbl_valid", 32'(valid_a), 32'(e.v));
            chk("tbl_stall", 32'(stall_a), 32'(e.st));
            chk("tbl_raw",   32'(raw_a),   32'(e.raw));
            chk("tbl_memw",  32'(mw_a),    32'(e.mw));
            chk("tbl_flush", 32'(flush_a), 32'(e.fl));
        end
        raw_a_seen = raw_a;
        raw_b_seen = raw_b;
        na = m_next(ma, x, 1'b1);
        nb = m_next(mb, x, 1'b0);
        @(posedge clk);
        ma = na;
        mb = nb;
        @(negedge clk);
        stepno++;
    endtask

    initial begin
        in_t idle, hz, x;
        int  cnt_a, cnt_b;
        none = '0;
        idle = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        hz   = mi(0, 1, 2, 1, 0, 0, 6, 1, 0, 0);

        // independent writers fill the pipe
        tbl[0]  = mk(mi(0, 1, 0, 0, 0, 0, 1, 1, 0, 0), 3'b000, 0, 0, 0, 0);
        tbl[1]  = mk(mi(0, 1, 0, 0, 0, 0, 2, 1, 0, 0), 3'b001, 0, 0, 0, 0);
        tbl[2]  = mk(mi(0, 1, 0, 0, 0, 0, 3, 1, 0, 0), 3'b011, 0, 0, 0, 0);
        tbl[3]  = mk(mi(0, 1, 0, 0, 0, 0, 4, 1, 0, 0), 3'b111, 0, 0, 0, 0);
        tbl[4]  = mk(mi(0, 1, 0, 0, 0, 0, 5, 1, 0, 0), 3'b111, 0, 0, 0, 0);
        tbl[5]  = mk(idle, 3'b111, 0, 0, 0, 0);
        tbl[6]  = mk(idle, 3'b110, 0, 0, 0, 0);
        tbl[7]  = mk(idle, 3'b100, 0, 0, 0, 0);
        tbl[8]  = mk(idle, 3'b000, 0, 0, 0, 0);
        // RAW on r2
        tbl[9]  = mk(mi(0, 1, 0, 0, 0, 0, 2, 1, 0, 0), 3'b000, 0, 0, 0, 0);
        tbl[10] = mk(hz, 3'b001, 1, 1, 0, 0);
        tbl[11] = mk(hz, 3'b010, 1, 1, 0, 0);
        tbl[12] = mk(hz, 3'b100, 0, 0, 0, 0);
        tbl[13] = mk(idle, 3'b001, 0, 0, 0, 0);
        tbl[14] = mk(idle, 3'b010, 0, 0, 0, 0);
        tbl[15] = mk(idle, 3'b100, 0, 0, 0, 0);
        tbl[16] = mk(idle, 3'b000, 0, 0, 0, 0);
        // load with 4 memory cycles
        tbl[17] = mk(mi(0, 1, 0, 0, 0, 0, 7, 1, 4, 0), 3'b000, 0, 0, 0, 0);
        tbl[18] = mk(idle, 3'b001, 0, 0, 0, 0);
        tbl[19] = mk(idle, 3'b010, 7, 0, 1, 0);
        tbl[20] = mk(idle, 3'b010, 7, 0, 1, 0);
        tbl[21] = mk(idle, 3'b010, 7, 0, 1, 0);
        tbl[22] = mk(idle, 3'b010, 0, 0, 0, 0);
        tbl[23] = mk(idle, 3'b100, 0, 0, 0, 0);
        tbl[24] = mk(idle, 3'b000, 0, 0, 0, 0);
        // taken branch squashes ID
        tbl[25] = mk(mi(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 3'b000, 0, 0, 0, 0);
        tbl[26] = mk(mi(0, 1, 0, 0, 0, 0, 8, 1, 0, 1), 3'b001, 0, 0, 0, 0);
        tbl[27] = mk(idle, 3'b010, 0, 0, 0, 1);
        tbl[28] = mk(idle, 3'b100, 0, 0, 0, 0);
        tbl[29] = mk(idle, 3'b000, 0, 0, 0, 0);
        // branch behind a 3-cycle load
        tbl[30] = mk(mi(0, 1, 0, 0, 0, 0, 9, 1, 3, 0), 3'b000, 0, 0, 0, 0);
        tbl[31] = mk(mi(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 3'b001, 0, 0, 0, 0);
        tbl[32] = mk(mi(0, 1, 0, 0, 0, 0, 10, 1, 0, 1), 3'b011, 7, 0, 1, 0);
        tbl[33] = mk(mi(0, 1, 0, 0, 0, 0, 10, 1, 0, 1), 3'b011, 7, 0, 1, 0);
        tbl[34] = mk(mi(0, 1, 0, 0, 0, 0, 10, 1, 0, 1), 3'b011, 0, 0, 0, 0);
        tbl[35] = mk(idle, 3'b110, 0, 0, 0, 1);
        tbl[36] = mk(idle, 3'b100, 0, 0, 0, 0);
        tbl[37] = mk(idle, 3'b000, 0, 0, 0, 0);
        // reset in the middle of a hold
        tbl[38] = mk(mi(0, 1, 0, 0, 0, 0, 11, 1, 4, 0), 3'b000, 0, 0, 0, 0);
        tbl[39] = mk(idle, 3'b001, 0, 0, 0, 0);
        tbl[40] = mk(idle, 3'b010, 7, 0, 1, 0);
        tbl[41] = mk(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 3'b010, 7, 0, 1, 0);
        tbl[42] = mk(idle, 3'b000, 0, 0, 0, 0);
        // register 0 interlocks like any other
        tbl[43] = mk(mi(0, 1, 0, 0, 0, 0, 0, 1, 0, 0), 3'b000, 0, 0, 0, 0);
        tbl[44] = mk(mi(0, 1, 0, 0, 0, 1, 12, 1, 0, 0), 3'b001, 1, 1, 0, 0);
        tbl[45] = mk(mi(0, 1, 0, 0, 0, 1, 12, 1, 0, 0), 3'b010, 1, 1, 0, 0);
        tbl[46] = mk(mi(0, 1, 0, 0, 0, 1, 12, 1, 0, 0), 3'b100, 0, 0, 0, 0);

        apply(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        ma = '0;
        mb = '0;

        for (int i = 0; i < 47; i++) step(tbl[i].stim, 1'b1, tbl[i]);

        for (int i = 0; i < 800; i++) begin
            x.rst    = ($urandom_range(0, 63) == 0);
            x.idv    = ($urandom_range(0, 3) != 0);
            x.rsa    = AW'($urandom_range(0, 3));
            x.rsa_en = $urandom_range(0, 1);
            x.rsb    = AW'($urandom_range(0, 3));
            x.rsb_en = $urandom_range(0, 1);
            x.rd     = AW'($urandom_range(0, 3));
            x.rd_en  = $urandom_range(0, 1);
            x.mem    = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 5)) : '0;
            x.br     = ($urandom_range(0, 3) == 0);
            step(x, 1'b0, none);
        end

        // interlock length with and without the WB write-through
        step(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, none);
        step(mi(0, 1, 0, 0, 0, 0, 2, 1, 0, 0), 1'b0, none);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            step(hz, 1'b0, none);
            cnt_a += int'(raw_a_seen);
            cnt_b += int'(raw_b_seen);
        end
        chk("raw_cycles_bypass", 32'(cnt_a), 32'd2);
        chk("raw_cycles_nobypass", 32'(cnt_b), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
